fp16_to_int_quant: RTL and testbench

Streaming, multi-lane FP16-to-signed-integer quantizer with a parametrised output width, a per-beat power-of-two scale, a selectable rounding mode, per-lane saturation flags and a sticky saturation counter. It sits between FP16 activation producers and integer MAC datapaths in the vector compute unit. It accepts one vector of `LANES` FP16 values per beat over a valid/ready handshake. Its 2-stage pipeline stalls cleanly under backpressure.

---
 rtl/fp16_to_int_quant_if.sv | 24 ++
 rtl/fp16_to_int_quant.sv | 154 +++++++++++++++
 tb/tb_fp16_to_int_quant.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_to_int_quant_if.sv
// Beat-level stream bundle for the FP16 quantizer: input vector + config, output vector + clamp flags.
interface fp16_to_int_quant_if #(
  parameter int LANES = 4,
  parameter int OUT_W = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0][15:0]       in_data;
  logic                         cfg_round;
  logic [3:0]                   cfg_scale;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES-1:0][OUT_W-1:0]  out_data;
  logic [LANES-1:0]             out_sat;

  modport master (
    output in_valid, in_data, cfg_round, cfg_scale, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  in_valid, in_data, cfg_round, cfg_scale, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fp16_to_int_quant.sv
// Multi-lane FP16 -> signed OUT_W quantizer: 2-stage stallable pipeline, pow2 scale,
// two rounding modes, per-lane clamp flags and a sticky saturating clamp counter.
module fp16_to_int_quant_lane #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld1_i,
  input  logic             ld2_i,
  input  logic [15:0]      fp_i,
  input  logic [3:0]       scale_i,
  input  logic             mode_i,
  output logic [OUT_W-1:0] q_o,
  output logic             sat_o
);
  localparam logic [23:0]      LIM_N = 24'd1 << (OUT_W-1);
  localparam logic [23:0]      LIM_P = LIM_N - 24'd1;
  localparam logic [OUT_W-1:0] QMAX  = OUT_W'(LIM_P);
  localparam logic [OUT_W-1:0] QMIN  = OUT_W'(LIM_N);

  logic [4:0]       exp;
  logic [5:0]       sh;
  logic [54:0]      aligned;
  logic [22:0]      mag_d, mag_q;
  logic             rnd_d, rnd_q, stk_d, stk_q, sgn_q, inf_d, inf_q, nan_d, nan_q;
  logic             inc;
  logic [23:0]      m2;
  logic [OUT_W-1:0] q_d, q_q;
  logic             sat_d, sat_q;

  // Place the 11-bit significand so bit 32 has weight 2^0; shift spans 0..44,
  // so the integer part (up to 2^22 * 1.x) never overflows 23 bits.
  always_comb begin
    exp     = fp_i[14:10];
    sh      = ((exp == 5'd0) ? 6'd1 : {1'b0, exp}) + 6'd7 + {{2{scale_i[3]}}, scale_i};
    aligned = {44'd0, exp != 5'd0, fp_i[9:0]} << sh;
    mag_d   = aligned[54:32];
    rnd_d   = aligned[31];
    stk_d   = |aligned[30:0];
    inf_d   = (exp == 5'h1f) && (fp_i[9:0] == 10'd0);
    nan_d   = (exp == 5'h1f) && (fp_i[9:0] != 10'd0);
  end

  always_comb begin
    inc   = mode_i ? (rnd_q && (stk_q || mag_q[0])) : rnd_q;
    m2    = {1'b0, mag_q} + {23'd0, inc};
    q_d   = '0;
    sat_d = 1'b0;
    if (nan_q) begin
      q_d = '0;
    end else if (inf_q) begin
      q_d   = sgn_q ? QMIN : QMAX;
      sat_d = 1'b1;
    end else if (sgn_q) begin
      if (m2 > LIM_N) begin
        q_d   = QMIN;
        sat_d = 1'b1;
      end else begin
        q_d = -m2[OUT_W-1:0];
      end
    end else if (m2 > LIM_P) begin
      q_d   = QMAX;
      sat_d = 1'b1;
    end else begin
      q_d = m2[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0; rnd_q <= 1'b0; stk_q <= 1'b0; sgn_q <= 1'b0;
      inf_q <= 1'b0; nan_q <= 1'b0; q_q <= '0; sat_q <= 1'b0;
    end else begin
      if (ld1_i) begin
        mag_q <= mag_d; rnd_q <= rnd_d; stk_q <= stk_d; sgn_q <= fp_i[15];
        inf_q <= inf_d; nan_q <= nan_d;
      end
      if (ld2_i) begin
        q_q   <= q_d;
        sat_q <= sat_d;
      end
    end
  end

  assign q_o   = q_q;
  assign sat_o = sat_q;
endmodule

module fp16_to_int_quant #(
  parameter int LANES = 4,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fp16_to_int_quant_if.slave  bus,
  input  logic                sat_clr,
  output logic [CNT_W-1:0]    sat_count
);
  logic [2:1]                  vld_pipe_q;
  logic                        s1_adv, s2_adv, in_fire, ld2, out_fire;
  logic                        mode_q;
  logic [LANES-1:0][OUT_W-1:0] q;
  logic [LANES-1:0]            sat;
  logic [CNT_W-1:0]            cnt_d, cnt_q;

  assign s2_adv   = !vld_pipe_q[2] || bus.out_ready;
  assign s1_adv   = !vld_pipe_q[1] || s2_adv;
  assign in_fire  = bus.in_valid && s1_adv;
  assign ld2      = s2_adv && vld_pipe_q[1];
  assign out_fire = vld_pipe_q[2] && bus.out_ready;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = vld_pipe_q[2];
  assign bus.out_data  = q;
  assign bus.out_sat   = sat;
  assign sat_count     = cnt_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp16_to_int_quant_lane #(.OUT_W(OUT_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld1_i   (in_fire),
      .ld2_i   (ld2),
      .fp_i    (bus.in_data[g]),
      .scale_i (bus.cfg_scale),
      .mode_i  (mode_q),
      .q_o     (q[g]),
      .sat_o   (sat[g])
    );
  end

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr)
      cnt_d = '0;
    else if (out_fire && |sat && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (s1_adv) vld_pipe_q[1] <= bus.in_valid;
      if (s2_adv) vld_pipe_q[2] <= vld_pipe_q[1];
      if (in_fire) mode_q <= bus.cfg_round;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fp16_to_int_quant.sv
// Scoreboard bench for fp16_to_int_quant: real-valued reference model, backpressure, counter, reset.
module tb_fp16_to_int_quant;
  localparam int LANES = 4;
  localparam int OW    = 8;

  logic        clk = 1'b0, rst_n = 1'b1, sat_clr = 1'b0;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  fp16_to_int_quant_if #(.LANES(LANES), .OUT_W(OW)) bus ();
  fp16_to_int_quant_if #(.LANES(LANES), .OUT_W(OW)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.cfg_round = bus.cfg_round;
  assign bus2.cfg_scale = bus.cfg_scale;
  assign bus2.out_ready = bus.out_ready;

  fp16_to_int_quant #(.LANES(LANES), .OUT_W(OW), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sat_clr(sat_clr), .sat_count(cnt16));
  fp16_to_int_quant #(.LANES(LANES), .OUT_W(OW), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .sat_clr(sat_clr), .sat_count(cnt2));

  typedef struct {
    logic [LANES-1:0][OW-1:0] q;
    logic [LANES-1:0]         s;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;
  int   m16 = 0, m2 = 0, out_cnt = 0, stall_cyc = 0;
  logic held = 1'b0;
  logic [31:0] held_q;
  logic bp_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact real arithmetic on the decoded value, then round and clamp.
  function automatic void model(input logic [15:0] f, input logic [3:0] sc, input logic md,
                                output logic [OW-1:0] q, output logic s);
    int     e;
    real    a, fl, fr;
    longint n, v, lim;
    lim = longint'(1) <<< (OW-1);
    if (f[14:10] == 5'h1f) begin
      if (f[9:0] == 10'd0) begin
        q = f[15] ? OW'(lim) : OW'(lim - 1);
        s = 1'b1;
      end else begin
        q = '0;
        s = 1'b0;
      end
      return;
    end
    a = (f[14:10] == 5'd0) ? real'(f[9:0]) : real'(1024 + int'(f[9:0]));
    e = ((f[14:10] == 5'd0) ? 1 : int'(f[14:10])) - 25 + int'($signed(sc));
    while (e > 0) begin a = a * 2.0; e--; end
    while (e < 0) begin a = a / 2.0; e++; end
    fl = $floor(a);
    fr = a - fl;
    n  = longint'(fl);
    if (md == 1'b0 ? (fr >= 0.5) : (fr > 0.5 || (fr == 0.5 && n[0]))) n++;
    v = f[15] ? -n : n;
    if (v > lim - 1) begin
      q = OW'(lim - 1); s = 1'b1;
    end else if (v < -lim) begin
      q = OW'(lim); s = 1'b1;
    end else begin
      q = OW'(v); s = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m16 = 0; m2 = 0; held = 1'b0;
    end else begin
      chk("sat_count", 32'(cnt16), 32'(m16));
      chk("sat_count_w2", 32'(cnt2), 32'(m2));
      if (held) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", 32'(bus.out_data), held_q);
      end
      held   = bus.out_valid && !bus.out_ready;
      held_q = 32'(bus.out_data);
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < LANES; i++) begin
          logic [OW-1:0] tq;
          logic          ts;
          model(bus.in_data[i], bus.cfg_scale, bus.cfg_round, tq, ts);
          mon_e.q[i] = tq;
          mon_e.s[i] = ts;
        end
        sb.push_back(mon_e);
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          for (int i = 0; i < LANES; i++) begin
            chk("lane_q", 32'(bus.out_data[i]), 32'(mon_e.q[i]));
            chk("lane_sat", 32'(bus.out_sat[i]), 32'(mon_e.s[i]));
          end
        end
      end
      if (sat_clr) begin
        m16 = 0; m2 = 0;
      end else if (bus.out_valid && bus.out_ready && |bus.out_sat) begin
        if (m16 < 65535) m16++;
        if (m2 < 3) m2++;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [LANES-1:0][15:0] d, input logic [3:0] sc, input logic md);
    int t = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.cfg_scale = sc;
    bus.cfg_round = md;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      stall_cyc++;
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(t < 200), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES-1:0][15:0] rand_beat();
    logic [LANES-1:0][15:0] d;
    logic [31:0] r;
    for (int i = 0; i < LANES; i++) begin
      r    = $urandom;
      d[i] = r[15:0];
      if (r[16]) d[i][14:10] = 5'($urandom_range(10, 22));
    end
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.cfg_round = 1'b0; bus.cfg_scale = 4'd0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_sat", 32'(bus.out_sat), 32'd0);
    chk("rst_sat_count", 32'(cnt16), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed rounding / saturation / special / scale vectors, lane 0 rightmost.
    send({16'h57F0, 16'h4100, 16'h3E00, 16'h3800}, 4'h0, 1'b0);
    send({16'h57F0, 16'h4100, 16'h3E00, 16'h3800}, 4'h0, 1'b1);
    send({16'h7C00, 16'hD804, 16'hD800, 16'h57FC}, 4'h0, 1'b0);
    send({16'hFC00, 16'hD804, 16'hD800, 16'h57FC}, 4'h0, 1'b1);
    send({16'h0001, 16'h8000, 16'h7E00, 16'h0000}, 4'h0, 1'b0);
    send({16'hBC00, 16'h3C00, 16'h3E00, 16'h3C00}, 4'h3, 1'b0);
    send({16'h3C00, 16'h3C00, 16'hBC00, 16'h3C00}, 4'hF, 1'b0);
    send({16'h3C00, 16'h3C00, 16'hBC00, 16'h3C00}, 4'hF, 1'b1);
    send({16'h5BFF, 16'h0400, 16'h3555, 16'hBC00}, 4'h8, 1'b1);
    send({16'h7BFF, 16'h03FF, 16'h2C00, 16'hC7FF}, 4'h7, 1'b0);
    drain();

    // First-beat latency on an empty pipe.
    send({4{16'h4000}}, 4'h0, 1'b0);
    @(negedge clk);
    chk("lat_edge1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge2", 32'(bus.out_valid), 32'd1);
    drain();

    // Saturation counter, including the 2-bit instance holding at 3.
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    repeat (3) send({4{16'h7C00}}, 4'h0, 1'b0);
    drain();
    chk("cnt3", 32'(cnt16), 32'd3);
    chk("cnt3_w2", 32'(cnt2), 32'd3);
    repeat (2) send({16'h3C00, 16'h3C00, 16'hFC00, 16'h3C00}, 4'h0, 1'b0);
    drain();
    chk("cnt5", 32'(cnt16), 32'd5);
    chk("cnt5_w2", 32'(cnt2), 32'd3);

    // Clear coinciding with a saturating handshake.
    bus.out_ready = 1'b0;
    send({4{16'h7C00}}, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("clr_pre_valid", 32'(bus.out_valid), 32'd1);
    sat_clr = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_wins", 32'(cnt16), 32'd0);
    chk("clr_wins_w2", 32'(cnt2), 32'd0);
    drain();

    // Full throughput with out_ready high.
    oc0 = out_cnt;
    stall_cyc = 0;
    for (int k = 0; k < 8; k++) send(rand_beat(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    chk("tput_stalls", 32'(stall_cyc), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("tput_outs", 32'(out_cnt - oc0), 32'd8);
    chk("tput_empty", 32'(bus.out_valid), 32'd0);
    drain();

    // Random beats under random backpressure.
    bp_en = 1'b1;
    for (int k = 0; k < 20; k++) send(rand_beat(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    bp_en = 1'b0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    drain();

    // Reset with two beats in flight.
    send({4{16'h7C00}}, 4'h0, 1'b0);
    drain();
    bus.out_ready = 1'b0;
    send({4{16'h4000}}, 4'h0, 1'b0);
    send({4{16'h4200}}, 4'h0, 1'b0);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_count", 32'(cnt16), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    oc0 = out_cnt;
    send({16'h3C00, 16'h4500, 16'hC100, 16'h3C00}, 4'h0, 1'b0);
    drain();
    chk("post_rst_outs", 32'(out_cnt - oc0), 32'd1);

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
